// File: rtl/uart_adc_link_pkg.sv
// Shared types and constants for the UART/ADC stream endpoint.
package uart_adc_link_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned FRAME_W = 16;

  localparam logic [BYTE_W-1:0] CMD_START = 8'h53;
  localparam logic [BYTE_W-1:0] CMD_STOP  = 8'h50;
  localparam logic [BYTE_W-1:0] CMD_READ  = 8'h52;
  localparam logic [BYTE_W-1:0] CMD_DECIM = 8'h44;

  typedef enum logic {RX_CMD, RX_ARG} rx_state_t;

  typedef enum logic [2:0] {TX_IDLE, TX_HDR, TX_MSB, TX_LSB, TX_CSUM} tx_state_t;

  // Sample widened to the 16-bit frame payload.
  typedef struct packed {
    logic [BYTE_W-1:0] msb;
    logic [BYTE_W-1:0] lsb;
  } frame_payload_t;

endpackage

// File: rtl/uart_adc_framer.sv
// Serialises one held sample into a HDR/MSB/LSB/CSUM byte frame on a valid/ready stream.
module uart_adc_framer
  import uart_adc_link_pkg::*;
#(
  parameter int unsigned      ADC_W = 12,
  parameter logic [BYTE_W-1:0] HDR  = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADC_W-1:0]  sample,
  input  logic              sample_valid,
  output logic              sample_take_c,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  tx_state_t      state;
  frame_payload_t frame;

  // A held sample is consumed when idle, or back-to-back as the checksum byte leaves.
  assign sample_take_c = sample_valid && ((state == TX_IDLE) || ((state == TX_CSUM) && tx_ready));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= TX_IDLE;
      frame    <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
    end else begin
      case (state)
        TX_IDLE: begin
          if (sample_take_c) begin
            frame    <= FRAME_W'(sample);
            tx_data  <= HDR;
            tx_valid <= 1'b1;
            state    <= TX_HDR;
          end
        end
        TX_HDR: begin
          if (tx_ready) begin
            tx_data <= frame.msb;
            state   <= TX_MSB;
          end
        end
        TX_MSB: begin
          if (tx_ready) begin
            tx_data <= frame.lsb;
            state   <= TX_LSB;
          end
        end
        TX_LSB: begin
          if (tx_ready) begin
            tx_data <= HDR ^ frame.msb ^ frame.lsb;
            state   <= TX_CSUM;
          end
        end
        TX_CSUM: begin
          if (tx_ready) begin
            if (sample_take_c) begin
              frame   <= FRAME_W'(sample);
              tx_data <= HDR;
              state   <= TX_HDR;
            end else begin
              tx_data  <= '0;
              tx_valid <= 1'b0;
              state    <= TX_IDLE;
            end
          end
        end
        default: begin
          tx_valid <= 1'b0;
          state    <= TX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_adc_link.sv
// UART stream endpoint: parses command bytes, decimates ADC samples and emits framed samples.
module uart_adc_link
  import uart_adc_link_pkg::*;
#(
  parameter int unsigned       ADC_W     = 12,
  parameter logic [BYTE_W-1:0] HDR       = 8'hA5,
  parameter int unsigned       DECIM_RST = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              rx_error,
  output logic              rx_ready,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  output logic              tx_error,
  input  logic              tx_ready,
  input  logic [ADC_W-1:0]  adc_data,
  input  logic              adc_valid,
  output logic              streaming,
  output logic [BYTE_W-1:0] drop_count
);

  rx_state_t         rx_state;
  logic              pending;
  logic [BYTE_W-1:0] decim;
  logic [BYTE_W-1:0] dcnt;
  logic              hold_full;
  logic [ADC_W-1:0]  hold_data;
  logic              rx_fire_c;
  logic              select_c;
  logic              take_c;

  assign tx_error  = 1'b0;
  assign rx_fire_c = rx_valid && rx_ready && !rx_error;

  // One-shot reads take priority over the streaming decimator.
  always_comb begin
    select_c = 1'b0;
    if (adc_valid) begin
      if (pending) begin
        select_c = 1'b1;
      end else if (streaming && (dcnt == (decim - 8'd1))) begin
        select_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_ready   <= 1'b0;
      rx_state   <= RX_CMD;
      streaming  <= 1'b0;
      pending    <= 1'b0;
      decim      <= BYTE_W'(DECIM_RST);
      dcnt       <= '0;
      hold_full  <= 1'b0;
      hold_data  <= '0;
      drop_count <= '0;
    end else begin
      rx_ready <= 1'b1;

      if (adc_valid) begin
        if (pending) begin
          pending <= 1'b0;
          dcnt    <= '0;
        end else if (streaming) begin
          dcnt <= (dcnt == (decim - 8'd1)) ? '0 : dcnt + 8'd1;
        end
      end

      // Single-entry holding register; full and not draining means the sample is lost.
      if (select_c && (!hold_full || take_c)) begin
        hold_full <= 1'b1;
        hold_data <= adc_data;
      end else begin
        if (take_c) begin
          hold_full <= 1'b0;
        end
        if (select_c && (drop_count != 8'hFF)) begin
          drop_count <= drop_count + 8'd1;
        end
      end

      // Command writes come last so they win over same-cycle capture updates.
      if (rx_fire_c) begin
        case (rx_state)
          RX_CMD: begin
            case (rx_data)
              CMD_START: streaming <= 1'b1;
              CMD_STOP:  streaming <= 1'b0;
              CMD_READ:  pending   <= 1'b1;
              CMD_DECIM: rx_state  <= RX_ARG;
              default:   ;
            endcase
          end
          RX_ARG: begin
            decim    <= (rx_data == 8'd0) ? 8'd1 : rx_data;
            dcnt     <= '0;
            rx_state <= RX_CMD;
          end
        endcase
      end
    end
  end

  uart_adc_framer #(
    .ADC_W (ADC_W),
    .HDR   (HDR)
  ) u_framer (
    .clk           (clk),
    .reset         (reset),
    .sample        (hold_data),
    .sample_valid  (hold_full),
    .sample_take_c (take_c),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready)
  );

endmodule

// File: tb/tb_uart_adc_link.sv
// Scoreboard bench for uart_adc_link: directed scenarios plus a randomized command/sample/backpressure mix.
`timescale 1ns/1ps
module tb_uart_adc_link;

  localparam int unsigned ADC_W = 12;
  localparam logic [7:0]  HDR   = 8'hA5;

  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_error;
  logic             rx_ready;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_error;
  logic             tx_ready;
  logic [ADC_W-1:0] adc_data;
  logic             adc_valid;
  logic             streaming;
  logic [7:0]       drop_count;

  uart_adc_link #(
    .ADC_W     (ADC_W),
    .HDR       (HDR),
    .DECIM_RST (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_error   (rx_error),
    .rx_ready   (rx_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_error   (tx_error),
    .tx_ready   (tx_ready),
    .adc_data   (adc_data),
    .adc_valid  (adc_valid),
    .streaming  (streaming),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int checks      = 0;
  int failures    = 0;
  int frames_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: expected samples (frames) in order, plus drop accounting.
  logic [ADC_W-1:0] exp_q[$];
  int m_stream, m_pend, m_decim, m_seen, m_arg, m_inflight, m_bytes, m_drop, m_rdy;

  always @(negedge clk) begin : model
    int done;
    bit sel;
    if (!reset) begin
      m_stream = 0; m_pend = 0; m_decim = 1; m_seen = 0; m_arg = 0;
      m_inflight = 0; m_bytes = 0; m_drop = 0; m_rdy = 0;
    end else begin
      done = 0;
      if (tx_valid && tx_ready) begin
        m_bytes++;
        if (m_bytes == 4) begin
          m_bytes = 0;
          done = 1;
        end
      end
      if (adc_valid) begin
        sel = 0;
        if (m_pend != 0) begin
          sel = 1; m_pend = 0; m_seen = 0;
        end else if (m_stream != 0) begin
          m_seen++;
          if (m_seen == m_decim) begin
            sel = 1; m_seen = 0;
          end
        end
        if (sel) begin
          // Capacity is one frame in flight plus one held sample.
          if (m_inflight - done < 2) begin
            exp_q.push_back(adc_data);
            m_inflight++;
          end else if (m_drop < 255) begin
            m_drop++;
          end
        end
      end
      m_inflight -= done;
      if (rx_valid && (m_rdy != 0) && !rx_error) begin
        if (m_arg != 0) begin
          m_decim = (rx_data == 8'd0) ? 1 : int'(rx_data);
          m_seen  = 0;
          m_arg   = 0;
        end else begin
          case (rx_data)
            8'h53:   m_stream = 1;
            8'h50:   m_stream = 0;
            8'h52:   m_pend   = 1;
            8'h44:   m_arg    = 1;
            default: ;
          endcase
        end
      end
      m_rdy = 1;
    end
  end

  // Monitor: compares every accepted byte against the frame of the oldest expected sample.
  int               mon_idx = 0;
  bit               have_cur;
  logic [ADC_W-1:0] cur;
  bit               prev_stall;
  logic [7:0]       prev_data;

  always @(negedge clk) begin : monitor
    int   s;
    logic [7:0] eb;
    if (!reset) begin
      mon_idx = 0; have_cur = 0; prev_stall = 0;
      exp_q.delete();
    end else begin
      if (prev_stall) begin
        chk("stall_valid_held", tx_valid, 1);
        chk("stall_data_held", tx_data, prev_data);
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (tx_valid && tx_ready) begin
        if (mon_idx == 0) begin
          frames_seen++;
          have_cur = (exp_q.size() != 0);
          checks++;
          if (have_cur) begin
            cur = exp_q.pop_front();
          end else begin
            failures++;
            $display("FAIL unexpected_frame: got start byte %0h expected no frame", tx_data);
          end
        end
        s = int'(cur);
        case (mon_idx)
          0:       eb = HDR;
          1:       eb = 8'(s / 256);
          2:       eb = 8'(s % 256);
          default: eb = HDR ^ 8'(s / 256) ^ 8'(s % 256);
        endcase
        if (have_cur) chk($sformatf("frame_byte%0d", mon_idx), tx_data, eb);
        mon_idx = (mon_idx + 1) % 4;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic e);
    rx_data  = b;
    rx_valid = 1'b1;
    rx_error = e;
    tick();
    rx_valid = 1'b0;
    rx_error = 1'b0;
  endtask

  task automatic adc_pulse(input logic [ADC_W-1:0] v);
    adc_data  = v;
    adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || mon_idx != 0 || tx_valid) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s: drain timeout got queue=%0d expected 0", name, exp_q.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    int n;
    reset = 1'b0; rx_data = '0; rx_valid = 1'b0; rx_error = 1'b0;
    tx_ready = 1'b0; adc_data = '0; adc_valid = 1'b0;
    repeat (3) tick();
    chk("reset_rx_ready", rx_ready, 0);
    chk("reset_tx_valid", tx_valid, 0);
    chk("reset_tx_data", tx_data, 0);
    reset = 1'b1;
    tick();
    chk("post_reset_rx_ready", rx_ready, 1);
    chk("post_reset_tx_valid", tx_valid, 0);
    chk("post_reset_streaming", streaming, 0);
    chk("post_reset_drop", drop_count, 0);
    chk("tx_error_zero", tx_error, 0);

    // One-shot read of 0xABC.
    tx_ready = 1'b1;
    f0 = frames_seen;
    send_byte(8'h52, 1'b0);
    adc_pulse(12'hABC);
    drain("read_drain", 50);
    repeat (10) tick();
    chk("read_frame_count", frames_seen - f0, 1);
    chk("read_streaming", streaming, 0);

    // Decimate by 3 while streaming.
    send_byte(8'h44, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h53, 1'b0);
    chk("start_streaming", streaming, 1);
    f0 = frames_seen;
    for (int i = 1; i <= 9; i++) begin
      adc_pulse(ADC_W'(i));
      repeat (19) tick();
    end
    drain("decim_drain", 50);
    chk("decim3_frames", frames_seen - f0, 3);
    send_byte(8'h50, 1'b0);
    chk("stop_streaming", streaming, 0);
    f0 = frames_seen;
    for (int i = 0; i < 3; i++) begin
      adc_pulse(ADC_W'(100 + i));
      repeat (9) tick();
    end
    drain("stopped_drain", 50);
    chk("stopped_frames", frames_seen - f0, 0);

    // Errored and unknown bytes are ignored; decim argument 0 means 1.
    send_byte(8'h53, 1'b1);
    tick();
    chk("err_start_ignored", streaming, 0);
    send_byte(8'h7F, 1'b0);
    tick();
    chk("unknown_ignored", streaming, 0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h53, 1'b0);
    f0 = frames_seen;
    for (int i = 0; i < 3; i++) begin
      adc_pulse(ADC_W'($urandom));
      repeat (9) tick();
    end
    drain("decim0_drain", 50);
    chk("decim0_frames", frames_seen - f0, 3);

    // Stalled sink with back-to-back samples: one framed, one held, rest dropped.
    tx_ready = 1'b0;
    f0 = frames_seen;
    for (int i = 0; i < 5; i++) adc_pulse(ADC_W'($urandom));
    send_byte(8'h50, 1'b0);
    repeat (5) tick();
    chk("stall_drop_model", drop_count, m_drop);
    chk("stall_drop_three", drop_count, 3);
    chk("stall_tx_valid", tx_valid, 1);
    chk("stall_tx_hdr", tx_data, HDR);
    tx_ready = 1'b1;
    drain("stall_drain", 50);
    chk("stall_frames", frames_seen - f0, 2);

    // Randomized commands, samples and backpressure.
    for (int c = 0; c < 800; c++) begin
      tx_ready  = ($urandom_range(0, 3) != 0);
      adc_valid = ($urandom_range(0, 3) == 0);
      adc_data  = ADC_W'($urandom);
      rx_valid  = ($urandom_range(0, 5) == 0);
      rx_error  = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 5))
        0:       rx_data = 8'h53;
        1:       rx_data = 8'h50;
        2:       rx_data = 8'h52;
        3:       rx_data = 8'h44;
        4:       rx_data = 8'($urandom_range(0, 4));
        default: rx_data = 8'($urandom);
      endcase
      tick();
    end
    adc_valid = 1'b0; rx_valid = 1'b0; rx_error = 1'b0;
    send_byte(8'h50, 1'b0);
    send_byte(8'h50, 1'b0);
    tx_ready = 1'b1;
    drain("random_drain", 400);
    chk("random_drop_count", drop_count, m_drop);
    chk("random_streaming", streaming, m_stream);

    // Reset in the middle of a frame abandons it.
    tx_ready = 1'b0;
    send_byte(8'h52, 1'b0);
    adc_pulse(12'h5C3);
    n = 0;
    while (!tx_valid && n < 10) begin
      tick();
      n++;
    end
    chk("reset_test_frame_started", tx_valid, 1);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    chk("reset_test_in_msb", tx_data, 8'h05);
    reset = 1'b0;
    #1;
    chk("async_reset_tx_valid", tx_valid, 0);
    chk("async_reset_drop", drop_count, 0);
    chk("async_reset_rx_ready", rx_ready, 0);
    repeat (2) tick();
    reset = 1'b1;
    tx_ready = 1'b1;
    f0 = frames_seen;
    repeat (30) tick();
    chk("no_partial_frame", frames_seen - f0, 0);
    chk("after_reset_tx_valid", tx_valid, 0);
    chk("after_reset_drop", drop_count, 0);
    chk("after_reset_rx_ready", rx_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_adc_link.md
Name: uart_adc_link

Overview:
Stream-side endpoint for the UART core. It consumes the core's receive byte stream (from_uart_*) as a command channel. It produces the core's transmit byte stream (to_uart_*) as framed ADC samples. Sits between the ADC capture logic and the UART core; all handshakes are valid/ready, with a transfer occurring on the cycle where valid&ready=1.

Parameters:
ADC_W, 12, ADC sample width; legal range 9..16
HDR, 8'hA5, frame header byte
DECIM_RST, 1, decimation factor after reset; 1..255

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (0 = in reset)
rx_data  input  8  command byte from UART core (from_uart_data)
rx_valid  input  1  command byte valid (from_uart_valid)
rx_error  input  1  framing/parity error flag for rx_data (from_uart_error)
rx_ready  output  1  accept command byte (to from_uart_ready)
tx_data  output  8  frame byte to UART core (to_uart_data)
tx_valid  output  1  frame byte valid (to_uart_valid)
tx_error  output  1  tied 0 (to to_uart_error)
tx_ready  input  1  UART core can accept byte (to_uart_ready)
adc_data  input  ADC_W  ADC sample
adc_valid  input  1  one-cycle sample strobe
streaming  output  1  continuous streaming enabled
drop_count  output  8  samples dropped because the holding register was full; saturates at 255

Behaviour:
- Reset (reset=0, asynchronous): rx_ready=0, tx_valid=0, tx_data=0, tx_error=0, streaming=0, drop_count=0, decim=DECIM_RST, both FSMs idle, holding register empty, one-shot pending cleared. A frame in flight is abandoned.
- rx_ready goes to 1 on the first clk edge after reset release and stays 1. The block never back-pressures.
- Receive FSM, states RX_CMD and RX_ARG. A byte is accepted when rx_valid&rx_ready=1.
  - Accepted byte with rx_error=1: discarded, state unchanged.
  - In RX_CMD:
    - 0x53 'S': streaming=1 next cycle.
    - 0x50 'P': streaming=0. A frame already in progress or held still completes.
    - 0x52 'R': sets one-shot pending.
    - 0x44 'D': go to RX_ARG.
    - Any other byte: ignored.
  - In RX_ARG: accepted byte loads decim (value 0 loads 1). Return to RX_CMD. Decimation counter cleared.
- Capture: on adc_valid=1.
  - If one-shot pending: the sample is selected, pending is cleared, and the decimation counter resets to 0.
  - Else if streaming=1: the counter increments. When it reaches decim-1, the sample is selected and the counter wraps to 0.
  - A selected sample loads the holding register if it is empty, or is emptied this cycle by the TX FSM. Otherwise it is dropped and drop_count increments, saturating.
  - 'S'/'P' processing on the same cycle as adc_valid takes effect from the next cycle.
- Transmit FSM, states TX_IDLE, TX_HDR, TX_MSB, TX_LSB, TX_CSUM.
  - TX_IDLE with holding register full: copy the sample to the frame register, clear the holding register, go to TX_HDR with tx_valid=1 and tx_data=HDR.
  - Each state holds tx_data and tx_valid stable until tx_ready=1, then advances.
  - MSB = sample zero-extended to 16 bits, bits [15:8]. LSB = bits [7:0]. CSUM = HDR^MSB^LSB.
  - After CSUM is accepted: if the holding register is full, go directly to TX_HDR with no idle cycle; else go to TX_IDLE with tx_valid=0.
- Minimum sample-to-tx_valid latency: 2 cycles (capture edge, then frame-register load edge).
- Throughput at most 1 frame per 4 byte times. Samples arriving faster are buffered one deep, then dropped.

Decomposition:
- Package uart_adc_link_pkg holds:
  - command byte constants CMD_START 8'h53, CMD_STOP 8'h50, CMD_READ 8'h52, CMD_DECIM 8'h44;
  - rx_state_t {RX_CMD, RX_ARG};
  - tx_state_t {TX_IDLE, TX_HDR, TX_MSB, TX_LSB, TX_CSUM}.
- One natural sub-module: uart_adc_framer, containing the TX FSM, the frame register and the checksum. It takes a sample plus load/busy handshake from the top level. The command parser, decimation and holding register stay in the top level.

Test Plan:
- Reset release, no stimulus -> rx_ready=1 after one edge; tx_valid=0, streaming=0, drop_count=0.
- Send 'R'; one adc_valid with adc_data=12'hABC; tx_ready=1 -> bytes A5, 0A, BC, 13 exactly once; streaming stays 0.
- Send 'D',0x03,'S'; 9 adc_valid strobes spaced 20 cycles with values 1..9 -> frames for samples 3, 6, 9 only. Then send 'P' -> no further frames.
- tx_ready held 0 with streaming, decim=1, 5 back-to-back adc_valid -> first sample in frame register, second held, drop_count=3. tx_valid and tx_data stay stable while stalled.
- Byte 0x53 with rx_error=1, then byte 0x7F -> streaming remains 0, no state change. Then 'D',0x00 -> decim=1.
- Assert reset during TX_MSB -> tx_valid drops immediately. After release no partial frame completes, and drop_count=0.
